// File: rtl/slider_pkg.sv
// Shared definitions for the 3x3 sliding-tile puzzle: cell and direction
// codes, board geometry, the home board and small geometry helpers.
package slider_pkg;

    localparam int CELL_W  = 4;
    localparam int IDX_W   = 4;
    localparam int NCELL   = 9;
    localparam int BOARD_W = NCELL * CELL_W;

    // Cell contents: BLNK is the empty slot, ONE..EIGHT are the tiles.
    typedef enum logic [CELL_W-1:0] {
        BLNK  = 4'd0,
        ONE   = 4'd1,
        TWO   = 4'd2,
        THREE = 4'd3,
        FOUR  = 4'd4,
        FIVE  = 4'd5,
        SIX   = 4'd6,
        SEVEN = 4'd7,
        EIGHT = 4'd8
    } state_t;

    // Direction in which the blank travels.
    typedef enum logic [1:0] {
        LEFT  = 2'd0,
        RIGHT = 2'd1,
        TOP   = 2'd2,
        DOWN  = 2'd3
    } dirn_t;

    // Move scheduler control states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        MOVE  = 2'd2
    } fsm_state_t;

    // Home board: cell 0 holds BLNK, cell k holds tile k; cell 0 sits in bits [3:0].
    localparam logic [BOARD_W-1:0] HOME_BOARD = 36'h8_7654_3210;

    // True when the blank at pos can travel in direction d without leaving the grid.
    function automatic logic move_legal(input logic [IDX_W-1:0] pos, input dirn_t d);
        logic [IDX_W-1:0] row;
        logic [IDX_W-1:0] col;
        row = pos / IDX_W'(3);
        col = pos % IDX_W'(3);
        case (d)
            LEFT:    move_legal = (col != IDX_W'(0));
            RIGHT:   move_legal = (col != IDX_W'(2));
            TOP:     move_legal = (row != IDX_W'(0));
            DOWN:    move_legal = (row != IDX_W'(2));
            default: move_legal = 1'b0;
        endcase
    endfunction

    // Index of the cell next to pos in direction d (only meaningful when legal).
    function automatic logic [IDX_W-1:0] move_target(input logic [IDX_W-1:0] pos, input dirn_t d);
        case (d)
            LEFT:    move_target = pos - IDX_W'(1);
            RIGHT:   move_target = pos + IDX_W'(1);
            TOP:     move_target = pos - IDX_W'(3);
            DOWN:    move_target = pos + IDX_W'(3);
            default: move_target = pos;
        endcase
    endfunction

endpackage

// File: rtl/slider_rr_arb.sv
// NREQ-way round-robin arbiter. ptr_q names the requester with top priority;
// after a grant it moves to the requester just after the winner.
module slider_rr_arb #(
    parameter int NREQ  = 2,
    parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ-1:0]  req_i,
    input  logic             take_i,
    output logic             valid_o,
    output logic [IDX_W-1:0] idx_o
);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] cand;

    // Pick the first active requester scanning upward from the pointer.
    // The scan runs from the far end so the nearest hit is written last.
    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        cand    = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = IDX_W'((int'(ptr_q) + k) % NREQ);
            if (req_i[cand]) begin
                valid_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

    // Advance the pointer past the winner whenever a grant is taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (take_i && valid_o) begin
            ptr_q <= IDX_W'((int'(idx_o) + 1) % NREQ);
        end
    end

endmodule

// File: rtl/slider_move_sched.sv
// Sliding-puzzle move scheduler: arbitrates blank-move requests, rejects
// moves that would push the blank off the grid, applies legal ones and
// acknowledges each request with a one-cycle pulse.
//
// Handshake: a requester raises req[i] with dir[i] stable and holds both
// until ack[i] pulses for one cycle; err is valid only while ack is high.
// The ack cycle itself never samples req, so a requester may keep req high
// through it (a new request) or drop it there.
module slider_move_sched
    import slider_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREQ-1:0]            req,
    input  logic [NREQ-1:0][1:0]       dir,
    output logic [NREQ-1:0]            ack,
    output logic                       err,
    output logic [BOARD_W-1:0]         board,
    output logic [IDX_W-1:0]           blank_pos,
    output logic [CNT_W-1:0]           moves,
    output logic                       solved,
    output logic                       busy
);

    localparam int WIN_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    fsm_state_t                     state_q, state_d;
    logic [WIN_W-1:0]               win_q, win_d;
    dirn_t                          dir_q, dir_d;
    logic [NCELL-1:0][CELL_W-1:0]   board_q, board_d;
    logic [IDX_W-1:0]               blank_q, blank_d;
    logic [CNT_W-1:0]               moves_q, moves_d;
    logic [NREQ-1:0]                ack_q, ack_d;
    logic                           err_q, err_d;

    logic                           arb_valid;
    logic [WIN_W-1:0]               arb_idx;
    logic                           arb_take;
    logic                           legal;
    logic [IDX_W-1:0]               nbr;

    slider_rr_arb #(
        .NREQ  (NREQ),
        .IDX_W (WIN_W)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req_i   (req),
        .take_i  (arb_take),
        .valid_o (arb_valid),
        .idx_o   (arb_idx)
    );

    assign legal = move_legal(blank_q, dir_q);
    assign nbr   = move_target(blank_q, dir_q);

    // Next-state and datapath updates for the IDLE -> CHECK -> MOVE sequence.
    always_comb begin
        state_d  = state_q;
        win_d    = win_q;
        dir_d    = dir_q;
        board_d  = board_q;
        blank_d  = blank_q;
        moves_d  = moves_q;
        ack_d    = '0;
        err_d    = 1'b0;
        arb_take = 1'b0;
        case (state_q)
            IDLE: begin
                // The ack cycle still sees the finished request's req high; skip it.
                if (arb_valid && (ack_q == '0)) begin
                    arb_take = 1'b1;
                    win_d    = arb_idx;
                    dir_d    = dirn_t'(dir[arb_idx]);
                    state_d  = CHECK;
                end
            end
            CHECK: begin
                if (!legal) begin
                    ack_d[win_q] = 1'b1;
                    err_d        = 1'b1;
                    state_d      = IDLE;
                end else begin
                    state_d = MOVE;
                end
            end
            MOVE: begin
                board_d[blank_q] = board_q[nbr];
                board_d[nbr]     = BLNK;
                blank_d          = nbr;
                if (moves_q != '1) begin
                    moves_d = moves_q + 1'b1;
                end
                ack_d[win_q] = 1'b1;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any move in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            win_q   <= '0;
            dir_q   <= LEFT;
            board_q <= HOME_BOARD;
            blank_q <= '0;
            moves_q <= '0;
            ack_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            dir_q   <= dir_d;
            board_q <= board_d;
            blank_q <= blank_d;
            moves_q <= moves_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    assign ack       = ack_q;
    assign err       = err_q;
    assign board     = board_q;
    assign blank_pos = blank_q;
    assign moves     = moves_q;
    assign solved    = (board_q == HOME_BOARD);
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_slider_move_sched.sv
// Bench for slider_move_sched: directed scenarios with literal expectations,
// then random two-requester traffic, all checked every cycle against a
// grid-level behavioural model.
module tb_slider_move_sched;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       req;
    logic [1:0][1:0]  dir;
    logic [1:0]       ack;
    logic             err;
    logic [35:0]      board;
    logic [3:0]       blank_pos;
    logic [15:0]      moves;
    logic             solved;
    logic             busy;

    int n_checks = 0;
    int n_err    = 0;
    int preload_cnt = 0;
    logic [1:0] exp_q[$];

    localparam logic [35:0] HOME = 36'h876543210;

    slider_move_sched #(.NREQ(2), .CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .dir       (dir),
        .ack       (ack),
        .err       (err),
        .board     (board),
        .blank_pos (blank_pos),
        .moves     (moves),
        .solved    (solved),
        .busy      (busy)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        req = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Issue one request and wait for its ack; lat counts edges from sampling to ack.
    task automatic do_move(input int i, input logic [1:0] d, output int lat, output logic e);
        bit done;
        req[i] = 1'b1;
        dir[i] = d;
        lat    = 0;
        done   = 0;
        e      = 1'bx;
        while (!done && lat < 20) begin
            tick();
            lat++;
            if (ack[i]) begin
                done = 1;
                e    = err;
            end
        end
        chk("ack_seen", done, 1);
        req[i] = 1'b0;
    endtask

    // Behavioural model: grid arithmetic plus a countdown to each ack.
    initial begin : model
        logic [3:0]  m_cells[9];
        logic [35:0] exp_b;
        logic [1:0]  m_ack, ack_now;
        logic        m_err, m_valid, m_legal;
        logic [15:0] m_moves;
        int m_blank, m_ptr, m_remain, m_win, m_tgt, preload_seen;
        int win, r, c, nr, nc;
        m_valid = 0;
        preload_seen = 0;
        m_remain = 0;
        forever begin
            @(negedge clk);
            if (preload_cnt != preload_seen) begin
                preload_seen = preload_cnt;
                m_moves = 16'hFFFF;
            end
            if (m_valid) begin
                for (int i = 0; i < 9; i++) exp_b[4*i +: 4] = m_cells[i];
                chk("ack", ack, m_ack);
                if (m_ack != 0) chk("err", err, m_err);
                chk("board", board, exp_b);
                chk("blank_pos", blank_pos, m_blank);
                chk("moves", moves, m_moves);
                chk("solved", solved, (exp_b == HOME));
                chk("busy", busy, (m_remain != 0));
            end
            if (rst) begin
                for (int i = 0; i < 9; i++) m_cells[i] = 4'(i);
                m_blank = 0; m_moves = 0; m_ptr = 0; m_remain = 0;
                m_ack = 0; m_err = 0; m_valid = 1;
            end else if (m_valid) begin
                ack_now = m_ack;
                m_ack = 0;
                m_err = 0;
                if (m_remain > 0) begin
                    m_remain--;
                    if (m_remain == 0) begin
                        m_ack[m_win] = 1'b1;
                        m_err = !m_legal;
                        if (m_legal) begin
                            m_cells[m_blank] = m_cells[m_tgt];
                            m_cells[m_tgt] = 4'd0;
                            m_blank = m_tgt;
                            if (m_moves != 16'hFFFF) m_moves++;
                        end
                    end
                end else if (ack_now == 0 && req != 0) begin
                    win = -1;
                    for (int k = 0; k < 2; k++) begin
                        if (win < 0 && req[(m_ptr + k) % 2]) win = (m_ptr + k) % 2;
                    end
                    m_ptr = (win + 1) % 2;
                    m_win = win;
                    r = m_blank / 3;
                    c = m_blank % 3;
                    nr = r; nc = c;
                    case (dir[win])
                        2'd0: nc = c - 1;
                        2'd1: nc = c + 1;
                        2'd2: nr = r - 1;
                        default: nr = r + 1;
                    endcase
                    m_legal = (nr >= 0 && nr <= 2 && nc >= 0 && nc <= 2);
                    m_tgt = nr * 3 + nc;
                    m_remain = m_legal ? 2 : 1;
                end
            end
        end
    end

    // Directed scenarios, then random traffic.
    initial begin : stim
        int lat, got;
        logic e;
        int exp_blank[4];
        logic exp_e[4];
        exp_blank = '{3, 6, 6, 6};
        exp_e     = '{1'b0, 1'b0, 1'b1, 1'b1};
        rst = 1'b1;
        req = '0;
        dir = '0;
        reset_dut();

        // Reset values
        chk("rst_board", board, HOME);
        chk("rst_solved", solved, 1);
        chk("rst_moves", moves, 0);
        chk("rst_busy", busy, 0);

        // Legal move right from home
        do_move(0, 2'd1, lat, e);
        chk("t1_lat", lat, 3);
        chk("t1_err", e, 0);
        chk("t1_board", board, 36'h876543201);
        chk("t1_blank", blank_pos, 1);
        chk("t1_moves", moves, 1);
        chk("t1_solved", solved, 0);

        // Illegal move left from home
        reset_dut();
        do_move(0, 2'd0, lat, e);
        chk("t2_lat", lat, 2);
        chk("t2_err", e, 1);
        chk("t2_board", board, HOME);
        chk("t2_moves", moves, 0);
        chk("t2_solved", solved, 1);

        // Both requesters held with dir=down
        reset_dut();
        exp_q.push_back(2'd0); exp_q.push_back(2'd1);
        exp_q.push_back(2'd0); exp_q.push_back(2'd1);
        dir[0] = 2'd3;
        dir[1] = 2'd3;
        req = 2'b11;
        got = 0;
        for (int cyc = 0; cyc < 80 && got < 4; cyc++) begin
            tick();
            if (ack != 0) begin
                chk("t3_grant", ack[1] ? 2'd1 : 2'd0, exp_q.pop_front());
                chk("t3_err", err, exp_e[got]);
                chk("t3_blank", blank_pos, exp_blank[got]);
                got++;
            end
        end
        chk("t3_ack_count", got, 4);
        req = '0;
        tick();

        // Right then left returns home
        reset_dut();
        do_move(0, 2'd1, lat, e);
        tick();
        do_move(1, 2'd0, lat, e);
        chk("t4_board", board, HOME);
        chk("t4_solved", solved, 1);
        chk("t4_moves", moves, 2);

        // Reset during MOVE aborts without ack
        reset_dut();
        req[0] = 1'b1;
        dir[0] = 2'd1;
        tick();
        chk("t5_busy_check", busy, 1);
        tick();
        chk("t5_busy_move", busy, 1);
        chk("t5_no_ack_yet", ack, 0);
        rst = 1'b1;
        req = '0;
        tick();
        chk("t5_no_ack", ack, 0);
        chk("t5_board", board, HOME);
        chk("t5_moves", moves, 0);
        rst = 1'b0;
        tick();

        // Saturated move counter
        reset_dut();
        force dut.moves_q = 16'hFFFF;
        preload_cnt++;
        tick();
        release dut.moves_q;
        chk("t6_preload", moves, 16'hFFFF);
        tick();
        do_move(0, 2'd1, lat, e);
        chk("t6_err", e, 0);
        chk("t6_blank", blank_pos, 1);
        chk("t6_moves_sat", moves, 16'hFFFF);
        tick();

        // Random traffic on both requesters with occasional resets
        reset_dut();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            if ($urandom_range(0, 199) == 0) begin
                rst = 1'b1;
                req = '0;
                tick();
                tick();
                rst = 1'b0;
            end
            for (int i = 0; i < 2; i++) begin
                if (req[i]) begin
                    if (ack[i]) begin
                        if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
                        else dir[i] = 2'($urandom_range(0, 3));
                    end
                end else if ($urandom_range(0, 3) == 0) begin
                    req[i] = 1'b1;
                    dir[i] = 2'($urandom_range(0, 3));
                end
            end
            tick();
        end
        req = '0;
        repeat (5) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", n_checks, n_err);
        $fatal(1, "watchdog expired");
    end

endmodule
